mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer with HI/LO registers for the 5-stage MIPS32 pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and runs a radix-2 iterative shift-add multiply or restoring divide. It holds the HI/LO architectural registers. It drives the D-stage stall term for any HI/LO-using instruction, which is ORed into the existing hazard stall.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_iter_core.sv | 72 +++++++
 rtl/mdu_sequencer.sv | 133 +++++++++++++
 tb/tb_mdu_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default width.
// The E-stage decoder that produces start_E/op_E imports the same op encoding.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Radix-2 shift-add multiply / restoring divide datapath with final sign correction.
// acc holds {upper accumulator, multiplier} for MUL and {remainder, quotient} for DIV.
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             load,
    input  logic             step_mul,
    input  logic             step_div,
    input  logic             fix,
    input  logic             is_div,
    input  logic             neg_q,
    input  logic             neg_r,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   b;
    logic               div_mode;
    logic               nq;
    logic               nr;
    logic               dz;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
        // Remainder < divisor, so the shifted remainder fits WIDTH+1 bits and diff's MSB is its sign.
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, b};
        prod_fix = nq ? -acc : acc;
        if (div_mode) begin
            res_hi = nr ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            res_lo = dz ? {WIDTH{1'b1}} : (nq ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc      <= {{WIDTH{1'b0}}, lo_in};
            b        <= b_in;
            div_mode <= is_div;
            nq       <= neg_q;
            nr       <= neg_r;
            dz       <= (b_in == {WIDTH{1'b0}});
        end else if (step_mul) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
        end else if (step_div) begin
            if (!diff[WIDTH])
                acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc <= {acc[2*WIDTH-2:0], 1'b0};
        end else if (fix) begin
            // Fold the correction into acc so res_* stays stable afterwards.
            acc <= {res_hi, res_lo};
            nq  <= 1'b0;
            nr  <= 1'b0;
            dz  <= 1'b0;
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO, the iteration FSM and the D-stage stall term.
// Signed ops run on magnitudes; signs are reapplied in the single FIX cycle.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_E,
    input  logic [2:0]       op_E,
    input  logic [WIDTH-1:0] rs_E,
    input  logic [WIDTH-1:0] rt_E,
    input  logic             abort,
    input  logic             md_use_D,
    output logic             busy,
    output logic             stall_md_D,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_e        state;
    md_state_e        next_state;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             step_mul;
    logic             step_div;
    logic             fix;
    logic             wr_hi;
    logic             wr_lo;
    logic             op_signed;
    logic             op_div;
    logic             sign_rs;
    logic             sign_rt;
    logic [WIDTH-1:0] mag_rs;
    logic [WIDTH-1:0] mag_rt;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign op_signed  = (op_E == MD_MULT) || (op_E == MD_DIV);
    assign op_div     = (op_E == MD_DIV) || (op_E == MD_DIVU);
    assign sign_rs    = op_signed & rs_E[WIDTH-1];
    assign sign_rt    = op_signed & rt_E[WIDTH-1];
    assign mag_rs     = sign_rs ? -rs_E : rs_E;
    assign mag_rt     = sign_rt ? -rt_E : rt_E;
    assign busy       = (state != IDLE);
    assign stall_md_D = md_use_D & (busy | (start_E & ~abort));

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step_mul   = 1'b0;
        step_div   = 1'b0;
        fix        = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (state)
            IDLE: begin
                if (start_E && !abort) begin
                    case (op_E)
                        MD_MULT, MD_MULTU: begin
                            load       = 1'b1;
                            next_state = MUL;
                        end
                        MD_DIV, MD_DIVU: begin
                            load       = 1'b1;
                            next_state = DIV;
                        end
                        MD_MTHI: wr_hi = 1'b1;
                        MD_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (abort) begin
                    next_state = IDLE;
                end else begin
                    step_mul = (state == MUL);
                    step_div = (state == DIV);
                    if (cnt == '0)
                        next_state = FIX;
                end
            end
            FIX: begin
                next_state = IDLE;
                fix        = !abort;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= next_state;
            if (load)
                cnt <= CW'(WIDTH - 1);
            else if (step_mul || step_div)
                cnt <= cnt - 1'b1;
            if (wr_hi)
                hi <= rs_E;
            else if (fix)
                hi <= res_hi;
            if (wr_lo)
                lo <= rs_E;
            else if (fix)
                lo <= res_lo;
        end
    end

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .load     (load),
        .step_mul (step_mul),
        .step_div (step_div),
        .fix      (fix),
        .is_div   (op_div),
        .neg_q    (sign_rs ^ sign_rt),
        .neg_r    (sign_rs),
        .lo_in    (op_div ? mag_rs : mag_rt),
        .b_in     (op_div ? mag_rt : mag_rs),
        .res_hi   (res_hi),
        .res_lo   (res_lo)
    );

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: a 64-bit arithmetic reference model feeds an expected queue
// that a monitor drains whenever busy falls; stall, MTHI/MTLO and reset are checked by the driver.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy_cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_E;
    logic [2:0]  op_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        abort;
    logic        md_use_D;
    logic        busy;
    logic        stall_md_D;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always #5 clk = ~clk;

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_E    (start_E),
        .op_E       (op_E),
        .rs_E       (rs_E),
        .rt_E       (rt_E),
        .abort      (abort),
        .md_use_D   (md_use_D),
        .busy       (busy),
        .stall_md_D (stall_md_D),
        .hi         (hi),
        .lo         (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference results straight from the architectural definition of each op.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
        longint          sa;
        longint          sb;
        longint          sr;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        h  = '0;
        l  = '0;
        if (op == MD_MULT) begin
            sr = sa * sb;
            h  = sr[63:32];
            l  = sr[31:0];
        end else if (op == MD_MULTU) begin
            ur = ua * ub;
            h  = ur[63:32];
            l  = ur[31:0];
        end else if (b == 32'd0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else if (op == MD_DIV) begin
            sr = sa / sb;
            l  = sr[31:0];
            sr = sa % sb;
            h  = sr[31:0];
        end else begin
            ur = ua / ub;
            l  = ur[31:0];
            ur = ua % ub;
            h  = ur[31:0];
        end
    endtask

    // Issue a MULT/DIV-class op at cycle 0; ab_cyc in 1..33 aborts that cycle, -1 means none.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int ab_cyc, input logic use_d);
        logic [31:0] eh;
        logic [31:0] el;
        exp_t        e;
        int          last;
        model(op, a, b, eh, el);
        last = (ab_cyc > 0) ? ab_cyc : 33;
        if (ab_cyc <= 0) begin
            model_hi = eh;
            model_lo = el;
        end
        e.hi          = model_hi;
        e.lo          = model_lo;
        e.busy_cycles = last;
        exp_q.push_back(e);
        md_use_D = use_d;
        start_E  = 1'b1;
        op_E     = op;
        rs_E     = a;
        rt_E     = b;
        for (int c = 0; c <= 34; c++) begin
            abort = (c == ab_cyc);
            @(negedge clk);
            chk("stall_md", {63'd0, stall_md_D}, {63'd0, use_d && (c <= last)});
            @(posedge clk);
            #1;
            start_E = 1'b0;
            op_E    = MD_NONE;
            rs_E    = $urandom;
            rt_E    = $urandom;
        end
        abort    = 1'b0;
        md_use_D = 1'b0;
    endtask

    task automatic run_mt(input logic is_hi, input logic [31:0] val, input logic ab, input logic use_d);
        if (!ab) begin
            if (is_hi) model_hi = val;
            else       model_lo = val;
        end
        md_use_D = use_d;
        start_E  = 1'b1;
        op_E     = is_hi ? MD_MTHI : MD_MTLO;
        rs_E     = val;
        rt_E     = $urandom;
        abort    = ab;
        @(negedge clk);
        chk("mt_stall", {63'd0, stall_md_D}, {63'd0, use_d & ~ab});
        @(posedge clk);
        #1;
        start_E  = 1'b0;
        op_E     = MD_NONE;
        abort    = 1'b0;
        md_use_D = 1'b0;
        rs_E     = $urandom;
        @(negedge clk);
        chk("mt_hi", {32'd0, hi}, {32'd0, model_hi});
        chk("mt_lo", {32'd0, lo}, {32'd0, model_lo});
        chk("mt_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom % 7)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: busy falling marks the cycle a result (or an abort) must be visible.
    int  bcnt = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bcnt      = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                bcnt++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_hi", {32'd0, hi}, {32'd0, e.hi});
                    chk("res_lo", {32'd0, lo}, {32'd0, e.lo});
                    chk("busy_len", 64'(bcnt), 64'(e.busy_cycles));
                end
                bcnt = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ops[4];
        int         ab;
        ops[0] = MD_MULT;
        ops[1] = MD_MULTU;
        ops[2] = MD_DIV;
        ops[3] = MD_DIVU;

        rst_n    = 1'b0;
        start_E  = 1'b0;
        op_E     = MD_NONE;
        rs_E     = '0;
        rt_E     = '0;
        abort    = 1'b0;
        md_use_D = 1'b1;
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        chk("rst_stall", {63'd0, stall_md_D}, 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        md_use_D = 1'b0;
        @(posedge clk);
        #1;

        run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1);
        run_md(MD_MULT, -32'sd3, 32'd7, -1, 1'b1);
        run_md(MD_DIV, -32'sd7, 32'd2, -1, 1'b0);
        run_md(MD_DIVU, 32'h1234_5678, 32'd0, -1, 1'b1);
        run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        run_md(MD_DIV, -32'sd5, 32'd0, -1, 1'b0);
        run_md(MD_DIV, 32'd1000, 32'd7, 10, 1'b1);
        run_md(MD_MULT, 32'd123, 32'd456, 33, 1'b1);
        run_mt(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        run_mt(1'b1, 32'h0BAD_F00D, 1'b0, 1'b1);
        run_mt(1'b0, 32'h1357_9BDF, 1'b0, 1'b0);

        for (int i = 0; i < 45; i++) begin
            if ($urandom % 6 == 0) begin
                run_mt(1'($urandom), pick_val(), ($urandom % 4 == 0), 1'($urandom));
            end else begin
                ab = ($urandom % 5 == 0) ? int'($urandom_range(1, 33)) : -1;
                run_md(ops[$urandom % 4], pick_val(), pick_val(), ab, 1'($urandom));
            end
        end

        // Asynchronous reset in cycle 5 of a multiply, with nonzero HI/LO beforehand.
        run_mt(1'b1, 32'h1111_2222, 1'b0, 1'b0);
        run_mt(1'b0, 32'h3333_4444, 1'b0, 1'b0);
        start_E = 1'b1;
        op_E    = MD_MULT;
        rs_E    = 32'd99;
        rt_E    = 32'd77;
        @(posedge clk);
        #1;
        start_E = 1'b0;
        op_E    = MD_NONE;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_hi", {32'd0, hi}, 64'd0);
        chk("arst_lo", {32'd0, lo}, 64'd0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_mt(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b1);
        run_md(MD_MULTU, 32'd6, 32'd7, -1, 1'b1);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
